// File: rtl/spi_mem_target_if.sv
// SPI pin bundle plus the target's status strobes, shared by the memory target and its initiator.
interface spi_mem_target_if;
    logic spi_clk;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;
    logic active;
    logic wr_strobe;
    logic cmd_err;

    modport master (
        output spi_clk, spi_cs, spi_mosi,
        input  spi_miso, active, wr_strobe, cmd_err
    );

    modport slave (
        input  spi_clk, spi_cs, spi_mosi,
        output spi_miso, active, wr_strobe, cmd_err
    );
endinterface

// File: rtl/spi_mem_target.sv
// SPI mode-0 byte-addressed memory target: READ 0x03, WRITE 0x02, read-status 0x05, 16-bit address.
// SPI pins are oversampled by clk (>= 4x spi_clk); the array resets to INIT_BYTE.
module spi_mem_target #(
    parameter int         ADDR_W    = 10,
    parameter int         DEPTH     = 1024,
    parameter logic [7:0] INIT_BYTE = 8'h00
) (
    input logic             clk,
    input logic             reset_n,
    spi_mem_target_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] ADDR_HI = 3'd2;
    localparam logic [2:0] ADDR_LO = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] WR_DATA = 3'd5;
    localparam logic [2:0] STATUS  = 3'd6;
    localparam logic [2:0] IGNORE  = 3'd7;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    logic [1:0]        sclk_sync_q, sclk_sync_d;
    logic [1:0]        cs_sync_q, cs_sync_d;
    logic [1:0]        mosi_sync_q, mosi_sync_d;
    logic              cs_prev_q, cs_prev_d;
    logic [2:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        sh_in_q, sh_in_d;
    logic [7:0]        sh_out_q, sh_out_d;
    logic [7:0]        addr_hi_q, addr_hi_d;
    logic              rd_op_q, rd_op_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              miso_q, miso_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic              cmd_err_q, cmd_err_d;
    logic              err_sticky_q, err_sticky_d;
    logic              wr_seen_q, wr_seen_d;
    logic [7:0]        mem_q [DEPTH];
    logic              mem_we;

    logic              sclk_rise, sclk_fall, cs_hi, cs_fall, byte_done;
    logic [7:0]        byte_nx, status_byte;
    logic [31:0]       addr_full;
    logic [ADDR_W-1:0] addr_idx, ptr_inc;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[0], bus.spi_clk};
        cs_sync_d   = {cs_sync_q[0], bus.spi_cs};
        mosi_sync_d = {mosi_sync_q[0], bus.spi_mosi};
        cs_prev_d   = cs_sync_q[1];
    end

    // Edges compare the two sync stages so a 4x clock still updates miso
    // before the initiator's next sampling edge.
    assign sclk_rise   = sclk_sync_q[0] & ~sclk_sync_q[1];
    assign sclk_fall   = ~sclk_sync_q[0] & sclk_sync_q[1];
    assign cs_hi       = cs_sync_q[1];
    assign cs_fall     = cs_prev_q & ~cs_sync_q[1];
    assign byte_nx     = {sh_in_q[6:0], mosi_sync_q[1]};
    assign byte_done   = sclk_rise && (bit_cnt_q == 3'd7);
    assign status_byte = {6'b0, err_sticky_q, wr_seen_q};
    assign addr_full   = {16'd0, addr_hi_q, byte_nx};
    assign addr_idx    = ADDR_W'(addr_full % DEPTH);
    assign ptr_inc     = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sh_in_d      = sh_in_q;
        sh_out_d     = sh_out_q;
        addr_hi_d    = addr_hi_q;
        rd_op_d      = rd_op_q;
        ptr_d        = ptr_q;
        miso_d       = miso_q;
        wr_strobe_d  = 1'b0;
        cmd_err_d    = 1'b0;
        err_sticky_d = err_sticky_q;
        wr_seen_d    = wr_seen_q;
        mem_we       = 1'b0;

        // CS high wins over a simultaneous 8th edge, so that byte is dropped.
        if (cs_hi) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            if (sclk_rise && state_q != IDLE && state_q != IGNORE) begin
                sh_in_d   = byte_nx;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                    end
                end
                CMD: begin
                    if (byte_done) begin
                        if (byte_nx == OP_READ || byte_nx == OP_WRITE) begin
                            state_d = ADDR_HI;
                            rd_op_d = (byte_nx == OP_READ);
                        end else if (byte_nx == OP_RDSR) begin
                            state_d  = STATUS;
                            sh_out_d = status_byte;
                        end else begin
                            state_d      = IGNORE;
                            cmd_err_d    = 1'b1;
                            err_sticky_d = 1'b1;
                        end
                    end
                end
                ADDR_HI: begin
                    if (byte_done) begin
                        addr_hi_d = byte_nx;
                        state_d   = ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    if (byte_done) begin
                        ptr_d = addr_idx;
                        if (rd_op_q) begin
                            state_d  = RD_DATA;
                            sh_out_d = mem_q[addr_idx];
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end
                RD_DATA, STATUS: begin
                    if (sclk_fall) begin
                        miso_d   = sh_out_q[7];
                        sh_out_d = {sh_out_q[6:0], 1'b0};
                    end
                    // Next byte is staged at the 8th rise, ready for the following fall.
                    if (byte_done) begin
                        if (state_q == RD_DATA) begin
                            ptr_d    = ptr_inc;
                            sh_out_d = mem_q[ptr_inc];
                        end else begin
                            sh_out_d = status_byte;
                        end
                    end
                end
                WR_DATA: begin
                    if (byte_done) begin
                        mem_we      = 1'b1;
                        wr_strobe_d = 1'b1;
                        wr_seen_d   = 1'b1;
                        ptr_d       = ptr_inc;
                    end
                end
                IGNORE: miso_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // CS sync starts low so a reset released mid-frame waits for a fresh CS fall.
            sclk_sync_q  <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            cs_prev_q    <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            sh_in_q      <= '0;
            sh_out_q     <= '0;
            addr_hi_q    <= '0;
            rd_op_q      <= 1'b0;
            ptr_q        <= '0;
            miso_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            cmd_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            wr_seen_q    <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            cs_prev_q    <= cs_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sh_in_q      <= sh_in_d;
            sh_out_q     <= sh_out_d;
            addr_hi_q    <= addr_hi_d;
            rd_op_q      <= rd_op_d;
            ptr_q        <= ptr_d;
            miso_q       <= miso_d;
            wr_strobe_q  <= wr_strobe_d;
            cmd_err_q    <= cmd_err_d;
            err_sticky_q <= err_sticky_d;
            wr_seen_q    <= wr_seen_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[ADDR_W'(i)] <= INIT_BYTE;
        end else if (mem_we) begin
            mem_q[ptr_q] <= byte_nx;
        end
    end

    assign bus.spi_miso  = miso_q;
    assign bus.active    = (state_q != IDLE);
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_spi_mem_target.sv
// Bench for spi_mem_target: bit-level SPI initiator at clk/4 with back-to-back frames,
// checked against a byte-level model of the memory and status register.
module tb_spi_mem_target;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n;
    spi_mem_target_if bus();

    spi_mem_target #(.ADDR_W(10), .DEPTH(DEPTH), .INIT_BYTE(8'h00)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_mem [DEPTH];
    logic m_wr_seen, m_err;
    int exp_wr_n, exp_err_n;

    always @(posedge clk) begin
        if (bus.wr_strobe === 1'b1) wr_cnt++;
        if (bus.cmd_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_wr_seen = 1'b0;
        m_err = 1'b0;
    endtask

    // Expected miso bytes for nb complete bytes of tx_q, and the frame's side effects.
    task automatic model(input int nb);
        int addr;
        logic [7:0] op;
        exp_q.delete();
        exp_wr_n = 0;
        exp_err_n = 0;
        for (int i = 0; i < nb; i++) exp_q.push_back(8'h00);
        if (nb == 0) return;
        op = tx_q[0];
        addr = 0;
        if (nb >= 3) addr = {tx_q[1], tx_q[2]};
        if (op == 8'h03) begin
            for (int i = 3; i < nb; i++) exp_q[i] = m_mem[(addr + i - 3) % DEPTH];
        end else if (op == 8'h02) begin
            for (int i = 3; i < nb; i++) begin
                m_mem[(addr + i - 3) % DEPTH] = tx_q[i];
                exp_wr_n++;
                m_wr_seen = 1'b1;
            end
        end else if (op == 8'h05) begin
            for (int i = 1; i < nb; i++) exp_q[i] = {6'b0, m_err, m_wr_seen};
        end else begin
            m_err = 1'b1;
            exp_err_n = 1;
        end
    endtask

    // Shift nbits of tx_q out; rst_bit >= 0 pulls reset_n low just before that bit's rise.
    task automatic run(input string tag, input int nbits, input int rst_bit);
        int wr0, err0;
        logic [7:0] cur, t;
        rx_q.delete();
        cur = '0;
        wr0 = wr_cnt;
        err0 = err_cnt;
        model(nbits / 8);
        bus.spi_cs = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            t = tx_q[b / 8];
            bus.spi_clk = 1'b0;
            bus.spi_mosi = t[7 - (b % 8)];
            repeat (2) @(negedge clk);
            if (b == rst_bit) begin
                t = exp_q[b / 8];
                chk({tag, " pre_rst_miso"}, 32'(bus.spi_miso), 32'(t[7 - (b % 8)]));
                reset_n = 1'b0;
                #1;
                chk({tag, " rst_miso"}, 32'(bus.spi_miso), 32'd0);
                chk({tag, " rst_active"}, 32'(bus.active), 32'd0);
                break;
            end
            if (b == 1) chk({tag, " active"}, 32'(bus.active), 32'd1);
            cur = {cur[6:0], bus.spi_miso};
            bus.spi_clk = 1'b1;
            if (b % 8 == 7) rx_q.push_back(cur);
            repeat (2) @(negedge clk);
        end
        bus.spi_clk = 1'b0;
        repeat (2) @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < rx_q.size(); i++)
            chk($sformatf("%s rx%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        chk({tag, " wr_strobes"}, 32'(wr_cnt - wr0), 32'(exp_wr_n));
        chk({tag, " cmd_errs"}, 32'(err_cnt - err0), 32'(exp_err_n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel, nbytes, nbits, a16;
        logic [7:0] op;
        reset_n = 1'b0;
        bus.spi_cs = 1'b1;
        bus.spi_clk = 1'b0;
        bus.spi_mosi = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset miso", 32'(bus.spi_miso), 32'd0);
        chk("reset active", 32'(bus.active), 32'd0);
        chk("reset wr_strobe", 32'(bus.wr_strobe), 32'd0);
        chk("reset cmd_err", 32'(bus.cmd_err), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        tx_q = '{8'h05, 8'h00};                          run("status0", 16, -1);
        tx_q = '{8'h02, 8'h00, 8'h10, 8'hA5, 8'h5A};     run("wr10", 40, -1);
        tx_q = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00};     run("rd10", 40, -1);
        tx_q = '{8'h05, 8'h00, 8'h00, 8'h00};            run("status1", 32, -1);
        tx_q = '{8'h02, 8'h03, 8'hFF, 8'h11, 8'h22};     run("wrwrap", 40, -1);
        tx_q = '{8'h03, 8'h03, 8'hFF, 8'h00, 8'h00};     run("rd3ff", 40, -1);
        tx_q = '{8'h03, 8'h00, 8'h00, 8'h00};            run("rd000", 32, -1);
        tx_q = '{8'h03, 8'h07, 8'hFF, 8'h00};            run("rd7ff", 32, -1);
        tx_q = '{8'h9F, 8'hFF, 8'hA5};                   run("badop", 24, -1);
        tx_q = '{8'h05, 8'h00, 8'h00};                   run("status3", 24, -1);
        tx_q = '{8'h02, 8'h00, 8'h20, 8'hC3};            run("abort", 29, -1);
        tx_q = '{8'h03, 8'h00, 8'h20, 8'h00};            run("rd20", 32, -1);

        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)       op = 8'h02;
            else if (sel < 8)  op = 8'h03;
            else if (sel == 8) op = 8'h05;
            else               op = 8'($urandom_range(6, 255));
            a16 = ($urandom_range(0, 63) << 10) | ((32'h3F8 + $urandom_range(0, 15)) & 32'h3FF);
            tx_q.delete();
            tx_q.push_back(op);
            tx_q.push_back(8'(a16 >> 8));
            tx_q.push_back(8'(a16));
            nbytes = $urandom_range(1, 4);
            for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
            nbits = tx_q.size() * 8;
            if ($urandom_range(0, 3) == 0) nbits -= $urandom_range(1, 7);
            run($sformatf("rand%0d", k), nbits, -1);
        end

        tx_q = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFF};     run("wr100", 40, -1);
        tx_q = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00};     run("rstrd", 40, 27);
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        tx_q = '{8'h05, 8'h00};                          run("status_post", 16, -1);
        tx_q = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h00};     run("rd_post", 40, -1);
        tx_q = '{8'h03, 8'h00, 8'h10, 8'h00};            run("rd10_post", 32, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
